tank_score_keeper: RTL and testbench
====================================

TANK_SCORE_KEEPER -- requirements
Module: tank_score_keeper

Interface
REQ-001 SHALL have parameter HP_INIT, default 5: hit points loaded at game start.
REQ-002 SHALL have parameter HP_MAX, default 7: hit-point ceiling; must fit 3 bits.
REQ-003 SHALL have parameter BONUS_STEP, default 10: kills per bonus hit point; legal range 4..31.
REQ-004 SHALL have parameter RESPAWN_CYCLES, default 16: clk cycles spent in RESPAWN; legal range 1..65535.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port game_en  input  1  level; 1 = game running, 0 = abort/idle.
REQ-008 SHALL have port enemy_hit  input  4  level per enemy tank a..d; rising edge = that enemy destroyed.
REQ-009 SHALL have port player_hit  input  1  level; rising edge = player tank destroyed.
REQ-010 SHALL have ports scorea, scoreb, scorec, scored  output  5 each  per-enemy kill counts.
REQ-011 SHALL have port total_score  output  7  sum of the four scores.
REQ-012 SHALL have port hp  output  3  current hit points.
REQ-013 SHALL have port mytank_state  output  1  1 = player tank alive, 0 = destroyed/respawning/over.
REQ-014 SHALL have port game_over  output  1  high while in OVER.
REQ-015 SHALL have port bonus_pulse  output  1  one-cycle strobe per bonus hit point granted.

Function
REQ-016 SHALL register enemy_hit and player_hit each cycle; event = current & ~previous; previous registers reset to 0.
REQ-017 SHALL implement states IDLE, PLAY, RESPAWN, OVER; game_en=0 forces IDLE next cycle from any state, with priority over all other transitions.
REQ-018 IDLE: scores, total_score, bonus counter cleared, hp=HP_INIT; when game_en=1, go to PLAY next cycle.
REQ-019 PLAY and RESPAWN: each enemy event increments its score by 1, saturating at 31; an increment blocked by saturation does not count anywhere.
REQ-020 total_score SHALL equal scorea+scoreb+scorec+scored in the same cycle; 7-bit result, no overflow possible.
REQ-021 Bonus counter, 5 bits: adds the number of counted kills in the cycle (0..4); if the sum is >= BONUS_STEP, subtract BONUS_STEP, set bonus_pulse for one cycle, and increment hp, saturating at HP_MAX; bonus_pulse still fires at saturation.
REQ-022 PLAY: a player event decrements hp; bonus increment applies first in the same cycle; resulting hp=0 -> OVER, else -> RESPAWN with timer loaded to RESPAWN_CYCLES-1.
REQ-023 RESPAWN: player events ignored; timer decrements each cycle; at timer 0, go to PLAY next cycle.
REQ-024 OVER: all events ignored; scores and hp held; game_over=1; leaves only via game_en=0.
REQ-025 mytank_state SHALL be 1 only in PLAY; it falls in the cycle after the player event and rises in the cycle PLAY is re-entered.
REQ-026 All outputs SHALL be registered; event-to-output latency is 2 cycles from the input edge (1 edge-detect + 1 update).

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, scores=0, total_score=0, hp=HP_INIT, mytank_state=0, game_over=0, bonus_pulse=0, bonus counter=0, timer=0, edge registers=0.
REQ-028 Reset asserted mid-game SHALL discard all progress; after release, behaviour is identical to power-up.

Verification
REQ-029 Reset release, game_en=1 -> PLAY after 1 cycle, hp=5, mytank_state=1, all scores 0.
REQ-030 Ten single rising edges on enemy_hit[0] -> scorea=10, total_score=10, exactly one bonus_pulse, hp=6.
REQ-031 enemy_hit=4'b1111 for one edge with bonus counter at 8 -> all scores +1, total +4, bonus counter=2, one bonus_pulse.
REQ-032 Five player_hit edges, each after RESPAWN completes (16 cycles) -> hp 4,3,2,1,0; mytank_state low 16 cycles each time; after the fifth, game_over=1 and further edges are ignored.
REQ-033 player_hit edge in the same cycle as a bonus, with hp=1 -> hp stays 1, state RESPAWN, no game_over.
REQ-034 enemy_hit[2] held at 31 kills, extra edge -> scorec stays 31, no total or bonus change; game_en=0 mid-RESPAWN -> IDLE, all cleared, hp=5.

Source files
------------

// File: rtl/tank_score_keeper_if.sv
// Signal bundle between the tank game logic and the score keeper.
// The master drives game controls and hit inputs; the slave returns scores and status.
interface tank_score_keeper_if;
  logic       game_en;
  logic [3:0] enemy_hit;
  logic       player_hit;
  logic [4:0] scorea;
  logic [4:0] scoreb;
  logic [4:0] scorec;
  logic [4:0] scored;
  logic [6:0] total_score;
  logic [2:0] hp;
  logic       mytank_state;
  logic       game_over;
  logic       bonus_pulse;

  modport master (
    output game_en, enemy_hit, player_hit,
    input  scorea, scoreb, scorec, scored, total_score, hp,
           mytank_state, game_over, bonus_pulse
  );

  modport slave (
    input  game_en, enemy_hit, player_hit,
    output scorea, scoreb, scorec, scored, total_score, hp,
           mytank_state, game_over, bonus_pulse
  );
endinterface

// File: rtl/tank_score_keeper.sv
// Tank game score keeper: per-enemy kill counts, bonus hit points,
// player hit points and the respawn/game-over state machine.
module tank_score_keeper #(
  parameter int HP_INIT        = 5,
  parameter int HP_MAX         = 7,
  parameter int BONUS_STEP     = 10,
  parameter int RESPAWN_CYCLES = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  tank_score_keeper_if.slave  bus
);

  localparam logic [2:0]  HP_INIT_L = 3'(HP_INIT);
  localparam logic [2:0]  HP_MAX_L  = 3'(HP_MAX);
  localparam logic [5:0]  STEP_L    = 6'(BONUS_STEP);
  localparam logic [15:0] TIMER_L   = 16'(RESPAWN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, RESPAWN, OVER} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  enemy_cur_reg, enemy_prev_reg;
  logic        player_cur_reg, player_prev_reg;
  logic [4:0]  score_reg [4];
  logic [4:0]  score_next [4];
  logic [6:0]  total_reg, total_next;
  logic [4:0]  bonus_reg, bonus_next;
  logic [2:0]  hp_reg, hp_next;
  logic [15:0] timer_reg, timer_next;
  logic        mytank_reg, mytank_next;
  logic        over_reg, over_next;
  logic        pulse_reg, pulse_next;

  // Inputs are registered first, so events are seen one cycle after the input edge.
  logic [3:0] enemy_evt;
  logic       player_evt;
  logic [3:0] counted;
  logic [2:0] kills;
  logic [5:0] bonus_sum;
  logic       bonus_hit;
  logic [2:0] hp_bonus;

  assign enemy_evt  = enemy_cur_reg & ~enemy_prev_reg;
  assign player_evt = player_cur_reg & ~player_prev_reg;

  // A kill on a saturated score is dropped entirely, including from the bonus count.
  for (genvar gi = 0; gi < 4; gi++) begin : g_enemy
    assign counted[gi] = enemy_evt[gi] && (score_reg[gi] != 5'd31);
  end

  assign kills     = {2'b0, counted[0]} + {2'b0, counted[1]}
                   + {2'b0, counted[2]} + {2'b0, counted[3]};
  assign bonus_sum = {1'b0, bonus_reg} + {3'b0, kills};
  assign bonus_hit = (bonus_sum >= STEP_L);
  assign hp_bonus  = (bonus_hit && (hp_reg != HP_MAX_L)) ? hp_reg + 3'd1 : hp_reg;

  always_comb begin
    state_next = state_reg;
    for (int i = 0; i < 4; i++) score_next[i] = score_reg[i];
    bonus_next = bonus_reg;
    hp_next    = hp_reg;
    timer_next = timer_reg;
    pulse_next = 1'b0;

    if (!bus.game_en || (state_reg == IDLE)) begin
      state_next = bus.game_en ? PLAY : IDLE;
      for (int i = 0; i < 4; i++) score_next[i] = 5'd0;
      bonus_next = 5'd0;
      hp_next    = HP_INIT_L;
      timer_next = 16'd0;
    end else if ((state_reg == PLAY) || (state_reg == RESPAWN)) begin
      for (int i = 0; i < 4; i++) score_next[i] = score_reg[i] + {4'b0, counted[i]};
      bonus_next = bonus_hit ? 5'(bonus_sum - STEP_L) : bonus_sum[4:0];
      pulse_next = bonus_hit;
      hp_next    = hp_bonus;
      if (state_reg == PLAY) begin
        // The bonus is applied before the hit, so a bonus can save the last hit point.
        if (player_evt) begin
          hp_next = hp_bonus - 3'd1;
          if (hp_next == 3'd0) begin
            state_next = OVER;
          end else begin
            state_next = RESPAWN;
            timer_next = TIMER_L;
          end
        end
      end else begin
        if (timer_reg == 16'd0) state_next = PLAY;
        else                    timer_next = timer_reg - 16'd1;
      end
    end

    total_next  = {2'b0, score_next[0]} + {2'b0, score_next[1]}
                + {2'b0, score_next[2]} + {2'b0, score_next[3]};
    mytank_next = (state_next == PLAY);
    over_next   = (state_next == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      enemy_cur_reg   <= 4'd0;
      enemy_prev_reg  <= 4'd0;
      player_cur_reg  <= 1'b0;
      player_prev_reg <= 1'b0;
      for (int i = 0; i < 4; i++) score_reg[i] <= 5'd0;
      total_reg       <= 7'd0;
      bonus_reg       <= 5'd0;
      hp_reg          <= HP_INIT_L;
      timer_reg       <= 16'd0;
      mytank_reg      <= 1'b0;
      over_reg        <= 1'b0;
      pulse_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      enemy_cur_reg   <= bus.enemy_hit;
      enemy_prev_reg  <= enemy_cur_reg;
      player_cur_reg  <= bus.player_hit;
      player_prev_reg <= player_cur_reg;
      for (int i = 0; i < 4; i++) score_reg[i] <= score_next[i];
      total_reg       <= total_next;
      bonus_reg       <= bonus_next;
      hp_reg          <= hp_next;
      timer_reg       <= timer_next;
      mytank_reg      <= mytank_next;
      over_reg        <= over_next;
      pulse_reg       <= pulse_next;
    end
  end

  assign bus.scorea       = score_reg[0];
  assign bus.scoreb       = score_reg[1];
  assign bus.scorec       = score_reg[2];
  assign bus.scored       = score_reg[3];
  assign bus.total_score  = total_reg;
  assign bus.hp           = hp_reg;
  assign bus.mytank_state = mytank_reg;
  assign bus.game_over    = over_reg;
  assign bus.bonus_pulse  = pulse_reg;

endmodule

// File: tb/tb_tank_score_keeper.sv
// Directed test of tank_score_keeper with default parameters; inputs driven
// and outputs sampled on the falling clock edge.
module tb_tank_score_keeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   pulse_cnt = 0;

  tank_score_keeper_if bus ();

  tank_score_keeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.bonus_pulse === 1'b1) pulse_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // One rising edge on the chosen inputs; returns once the resulting update is visible.
  task automatic pulse_in(input logic [3:0] mask, input logic ph);
    bus.enemy_hit  = mask;
    bus.player_hit = ph;
    @(negedge clk);
    bus.enemy_hit  = 4'd0;
    bus.player_hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tank(output int n);
    n = 0;
    while (!bus.mytank_state && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic restart_game();
    bus.game_en = 1'b0;
    @(negedge clk);
    bus.game_en = 1'b1;
    @(negedge clk);
  endtask

  int n_low;
  int p0;

  initial begin
    bus.game_en    = 1'b0;
    bus.enemy_hit  = 4'd0;
    bus.player_hit = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_hp", 32'(bus.hp), 5);
    check_val("rst_total", 32'(bus.total_score), 0);
    check_val("rst_mytank", 32'(bus.mytank_state), 0);
    check_val("rst_over", 32'(bus.game_over), 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.game_en = 1'b1;
    @(negedge clk);
    check_val("start_mytank", 32'(bus.mytank_state), 1);
    check_val("start_hp", 32'(bus.hp), 5);
    check_val("start_scorea", 32'(bus.scorea), 0);

    // Player loses all five hit points.
    repeat (3) pulse_in(4'b0001, 1'b0);
    check_val("pre_hits_scorea", 32'(bus.scorea), 3);
    for (int i = 0; i < 5; i++) begin
      pulse_in(4'b0000, 1'b1);
      check_val($sformatf("hit%0d_hp", i), 32'(bus.hp), 32'(4 - i));
      check_val($sformatf("hit%0d_mytank", i), 32'(bus.mytank_state), 0);
      if (i < 4) begin
        wait_tank(n_low);
        check_val($sformatf("hit%0d_respawn_len", i), 32'(n_low), 16);
      end
    end
    check_val("over_flag", 32'(bus.game_over), 1);
    pulse_in(4'b0001, 1'b1);
    repeat (20) @(negedge clk);
    check_val("over_scorea_held", 32'(bus.scorea), 3);
    check_val("over_hp_held", 32'(bus.hp), 0);
    check_val("over_still", 32'(bus.game_over), 1);
    check_val("over_mytank", 32'(bus.mytank_state), 0);

    // Bonus hit point after ten kills.
    restart_game();
    check_val("restart_over", 32'(bus.game_over), 0);
    check_val("restart_scorea", 32'(bus.scorea), 0);
    p0 = pulse_cnt;
    repeat (9) pulse_in(4'b0001, 1'b0);
    check_val("nine_kills_hp", 32'(bus.hp), 5);
    check_val("nine_kills_pulses", 32'(pulse_cnt - p0), 0);
    pulse_in(4'b0001, 1'b0);
    check_val("ten_scorea", 32'(bus.scorea), 10);
    check_val("ten_total", 32'(bus.total_score), 10);
    check_val("ten_pulses", 32'(pulse_cnt - p0), 1);
    check_val("ten_hp", 32'(bus.hp), 6);

    // Four simultaneous kills crossing the bonus threshold from 8.
    repeat (8) pulse_in(4'b0010, 1'b0);
    p0 = pulse_cnt;
    pulse_in(4'b1111, 1'b0);
    check_val("all4_scorea", 32'(bus.scorea), 11);
    check_val("all4_scoreb", 32'(bus.scoreb), 9);
    check_val("all4_scorec", 32'(bus.scorec), 1);
    check_val("all4_scored", 32'(bus.scored), 1);
    check_val("all4_total", 32'(bus.total_score), 22);
    check_val("all4_pulses", 32'(pulse_cnt - p0), 1);
    check_val("all4_hp", 32'(bus.hp), 7);
    // Counter left at 2: the eighth further kill grants a bonus, hp already at ceiling.
    p0 = pulse_cnt;
    repeat (7) pulse_in(4'b1000, 1'b0);
    check_val("resid_7_pulses", 32'(pulse_cnt - p0), 0);
    pulse_in(4'b1000, 1'b0);
    check_val("resid_8_pulses", 32'(pulse_cnt - p0), 1);
    check_val("hp_sat", 32'(bus.hp), 7);
    check_val("resid_total", 32'(bus.total_score), 30);

    // Bonus in the same cycle as the hit that would have ended the game.
    restart_game();
    for (int i = 0; i < 4; i++) begin
      pulse_in(4'b0000, 1'b1);
      wait_tank(n_low);
    end
    check_val("hp_down_to_1", 32'(bus.hp), 1);
    repeat (9) pulse_in(4'b0100, 1'b0);
    p0 = pulse_cnt;
    pulse_in(4'b1000, 1'b1);
    check_val("save_hp", 32'(bus.hp), 1);
    check_val("save_over", 32'(bus.game_over), 0);
    check_val("save_mytank", 32'(bus.mytank_state), 0);
    check_val("save_pulses", 32'(pulse_cnt - p0), 1);
    wait_tank(n_low);
    check_val("save_respawn_len", 32'(n_low), 16);

    // Score saturation on enemy c.
    p0 = pulse_cnt;
    repeat (22) pulse_in(4'b0100, 1'b0);
    check_val("sat_scorec", 32'(bus.scorec), 31);
    check_val("sat_total", 32'(bus.total_score), 32);
    check_val("sat_pulses", 32'(pulse_cnt - p0), 2);
    check_val("sat_hp", 32'(bus.hp), 3);
    p0 = pulse_cnt;
    pulse_in(4'b0100, 1'b0);
    @(negedge clk);
    check_val("extra_scorec", 32'(bus.scorec), 31);
    check_val("extra_total", 32'(bus.total_score), 32);
    check_val("extra_pulses", 32'(pulse_cnt - p0), 0);

    // Abort in the middle of a respawn.
    pulse_in(4'b0000, 1'b1);
    check_val("abort_pre_hp", 32'(bus.hp), 2);
    repeat (3) @(negedge clk);
    bus.game_en = 1'b0;
    @(negedge clk);
    check_val("abort_hp", 32'(bus.hp), 5);
    check_val("abort_total", 32'(bus.total_score), 0);
    check_val("abort_scorec", 32'(bus.scorec), 0);
    check_val("abort_mytank", 32'(bus.mytank_state), 0);
    repeat (20) @(negedge clk);
    check_val("idle_mytank", 32'(bus.mytank_state), 0);

    // Reset in the middle of a game.
    bus.game_en = 1'b1;
    @(negedge clk);
    pulse_in(4'b0001, 1'b0);
    check_val("pre_rst_scorea", 32'(bus.scorea), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_scorea", 32'(bus.scorea), 0);
    check_val("async_rst_mytank", 32'(bus.mytank_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_mytank", 32'(bus.mytank_state), 1);
    check_val("post_rst_hp", 32'(bus.hp), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
